sram_to_sbus: RTL and testbench
===============================

# sram_to_sbus

Initiator-side bridge from the core's SRAM-style data port onto the system bus (`sbus`). It takes a byte-enable-masked request from the core and turns it into a single sized, lane-aligned `sbus` master transaction. It holds that transaction through slave stalls, then returns low-aligned read data to its byte lanes. It sits between the CPU data port and the bus interconnect, facing the existing SRAM-side slave adapters.

## Interface
Parameters:
- `STALL_LIMIT`, default 16: maximum consecutive stalled `BUSY` cycles before abort. Only used with `SRAM_TO_SBUS_TIMEOUT_EN`; legal range 1..255.

Ports:
- `clk`  input  1  single clock; all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `sram_en`  input  1  core request valid
- `sram_wr`  input  1  1 = write, 0 = read
- `sram_be`  input  4  byte enables, lane i = bits [8i+7:8i]
- `sram_addr`  input  `W_ADDR` (32)  byte address; bits [1:0] ignored
- `sram_wdata`  input  `W_DATA` (32)  lane-positioned write data
- `sram_rdata`  output  `W_DATA`  lane-positioned read data, valid only while `sram_done`=1, else 0
- `sram_stall`  output  1  bridge busy; request not accepted this cycle
- `sram_done`  output  1  one-cycle pulse: write accepted by slave, or read data valid, or error
- `sram_err`  output  1  qualifies `sram_done`: illegal `sram_be` or timeout
- `sbus`  `sbus.master`  —  en, we, size[1:0], addr, data_w out; data_r, stall in

## Operation
- States: `IDLE`, `BUSY`, `RESP`.
- `sram_stall` = (state != `IDLE`).
- A request is accepted in a cycle with `sram_en`=1 while in `IDLE`. On acceptance the bridge registers we, size, offset, shifted write data and `{sram_addr[31:2], off}`.
- `sram_be` decode (size, off):
  - 0001 → (0,0); 0010 → (0,1); 0100 → (0,2); 1000 → (0,3)
  - 0011 → (1,0); 1100 → (1,2)
  - 1111 → (2,0)
  - Any other value is illegal.
- Write data: `data_w = sram_wdata >> (8*off)`, with the selected bytes in the low bits.
- Read data: `sram_rdata = sbus.data_r << (8*off)`; bytes outside `sram_be` are 0.
- Legal request: `IDLE` → `BUSY`.
  - In `BUSY`, `sbus.en`=1 and all `sbus` outputs come from registers and stay stable.
  - If `sbus.stall`=1, stay in `BUSY`.
  - If `sbus.stall`=0 and write: `sram_done`=1 in that cycle, then → `IDLE`.
  - If `sbus.stall`=0 and read: → `RESP`.
- `RESP`: sample `sbus.data_r` combinationally; `sram_done`=1, `sram_rdata` valid; → `IDLE`.
- Illegal `sram_be`: no `sbus` transaction. `IDLE` → `RESP` with an error flag; in `RESP`, `sram_done`=1, `sram_err`=1, `sram_rdata`=0.
- `sram_en`=0 in `IDLE`: no action.
- Inputs presented while `sram_stall`=1 are ignored; the core holds them.

## Timing
- Reset (`rst`=0, asynchronous):
  - state `IDLE`; all request registers 0; timeout counter 0.
  - `sbus.en`/`we`/`size`/`addr`/`data_w` = 0.
  - `sram_stall`/`sram_done`/`sram_err`/`sram_rdata` = 0.
- Reset asserted mid-transaction abandons it; `sbus.en` drops without waiting for a clock.
- Unstalled write: accept at N, `sbus.en` at N+1, `sram_done` at N+1, next accept possible at N+2.
- Unstalled read: accept at N, `sbus.en` at N+1, `sram_done` + data at N+2, next accept at N+3.
- Each stalled cycle adds exactly one cycle of latency.
- Illegal mask: accept at N, `sram_done`+`sram_err` at N+1.
- `sbus.en` is never asserted in `IDLE` or `RESP`; there is at most one outstanding transaction.

## Configuration
- `SRAM_TO_SBUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to `BUSY` and increments on each `BUSY` cycle with `sbus.stall`=1.
  - When it reaches `STALL_LIMIT` with stall still high, `sbus.en` drops next cycle and the bridge goes to `RESP` with `sram_err`=1 and `sram_rdata`=0, for reads and writes alike.
- Undefined: no counter; `BUSY` waits indefinitely for `sbus.stall`=0.

## Test plan
- Word write, `sram_be`=1111, addr 0x1000_0004, wdata 0xDEADBEEF, no stall → `sbus` en=1, we=1, size=2, addr 0x1000_0004, data_w 0xDEADBEEF at N+1; `sram_done` at N+1.
- Byte write, `sram_be`=0100, addr 0x80, wdata 0x00AB_0000 → size=0, addr 0x82, data_w 0x0000_00AB.
- Halfword read, `sram_be`=1100, addr 0x40, slave `data_r`=0x0000_1234 → size=1, addr 0x42; at N+2 `sram_done`=1, `sram_rdata`=0x1234_0000.
- Read with `sbus.stall` high for 3 cycles → `sbus` outputs stable throughout; `sram_done` at N+5; `sram_stall`=1 from N+1 to N+5.
- Illegal `sram_be`=0110 → `sbus.en` never asserted; `sram_done`=`sram_err`=1 at N+1. With `SRAM_TO_SBUS_TIMEOUT_EN` and `STALL_LIMIT`=4, permanent stall → `sram_err` pulse and `sbus.en` released.
- Drive `rst`=0 during `BUSY` → `sbus.en`=0 and `sram_stall`=0 immediately; after release, a new request is accepted normally.

Source files
------------

// File: rtl/sram_to_sbus.sv
// Bridge from the core's byte-enable SRAM data port to a single sized, lane-aligned sbus master transaction.
// Optional stall timeout enabled by defining SRAM_TO_SBUS_TIMEOUT_EN.
module sram_to_sbus #(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic        sram_wr,
    input  logic [3:0]  sram_be,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_stall,
    output logic        sram_done,
    output logic        sram_err,
    output logic        sbus_en,
    output logic        sbus_we,
    output logic [1:0]  sbus_size,
    output logic [31:0] sbus_addr,
    output logic [31:0] sbus_data_w,
    input  logic [31:0] sbus_data_r,
    input  logic        sbus_stall
);

    localparam int unsigned W_ADDR = 32;
    localparam int unsigned W_DATA = 32;

    if (STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_limit_check
        $error("sram_to_sbus: STALL_LIMIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        req_we;
    logic        req_err;
    logic [1:0]  req_size;
    logic [1:0]  req_off;

    logic        dec_ok;
    logic [1:0]  dec_size;
    logic [1:0]  dec_off;
    logic [W_DATA-1:0] rd_mask;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, sram_addr[1:0]};

`ifdef SRAM_TO_SBUS_TIMEOUT_EN
    localparam logic [7:0] LIMIT_M1 = 8'(STALL_LIMIT - 1);
    logic [7:0] stall_cnt;
`endif

    // Byte-enable mask to (size, lane offset); only naturally aligned masks are legal.
    always_comb begin
        dec_ok   = 1'b1;
        dec_size = 2'd0;
        dec_off  = 2'd0;
        case (sram_be)
            4'b0001: dec_off = 2'd0;
            4'b0010: dec_off = 2'd1;
            4'b0100: dec_off = 2'd2;
            4'b1000: dec_off = 2'd3;
            4'b0011: dec_size = 2'd1;
            4'b1100: begin dec_size = 2'd1; dec_off = 2'd2; end
            4'b1111: dec_size = 2'd2;
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            req_we      <= 1'b0;
            req_err     <= 1'b0;
            req_size    <= 2'd0;
            req_off     <= 2'd0;
            sram_stall  <= 1'b0;
            sbus_en     <= 1'b0;
            sbus_we     <= 1'b0;
            sbus_size   <= 2'd0;
            sbus_addr   <= '0;
            sbus_data_w <= '0;
`ifdef SRAM_TO_SBUS_TIMEOUT_EN
            stall_cnt   <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sram_en) begin
                        sram_stall <= 1'b1;
                        req_we     <= sram_wr;
                        req_size   <= dec_size;
                        req_off    <= dec_off;
                        if (dec_ok) begin
                            state       <= BUSY;
                            req_err     <= 1'b0;
                            sbus_en     <= 1'b1;
                            sbus_we     <= sram_wr;
                            sbus_size   <= dec_size;
                            sbus_addr   <= {sram_addr[W_ADDR-1:2], dec_off};
                            sbus_data_w <= sram_wdata >> {dec_off, 3'b000};
`ifdef SRAM_TO_SBUS_TIMEOUT_EN
                            stall_cnt   <= 8'd0;
`endif
                        end else begin
                            state   <= RESP;
                            req_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!sbus_stall) begin
                        sbus_en <= 1'b0;
                        if (req_we) begin
                            state      <= IDLE;
                            sram_stall <= 1'b0;
                        end else begin
                            state <= RESP;
                        end
                    end else begin
`ifdef SRAM_TO_SBUS_TIMEOUT_EN
                        // Abort after STALL_LIMIT consecutive stalled cycles.
                        stall_cnt <= stall_cnt + 8'd1;
                        if (stall_cnt == LIMIT_M1) begin
                            sbus_en <= 1'b0;
                            req_err <= 1'b1;
                            state   <= RESP;
                        end
`endif
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    sram_stall <= 1'b0;
                    req_err    <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    sram_stall <= 1'b0;
                    sbus_en    <= 1'b0;
                end
            endcase
        end
    end

    // Write completion is reported in the unstalled BUSY cycle; reads and errors in RESP.
    assign sram_done = (state == RESP) || ((state == BUSY) && !sbus_stall && req_we);
    assign sram_err  = (state == RESP) && req_err;

    always_comb begin
        rd_mask = '1;
        case (req_size)
            2'd0:    rd_mask = 32'h0000_00FF;
            2'd1:    rd_mask = 32'h0000_FFFF;
            default: rd_mask = '1;
        endcase
        sram_rdata = '0;
        if ((state == RESP) && !req_err) begin
            sram_rdata = (sbus_data_r & rd_mask) << {req_off, 3'b000};
        end
    end

endmodule

// File: tb/tb_sram_to_sbus.sv
// Scoreboard bench for sram_to_sbus: directed requests, bus and response monitors.
module tb_sram_to_sbus;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_en;
    logic        sram_wr;
    logic [3:0]  sram_be;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_stall;
    logic        sram_done;
    logic        sram_err;
    logic        sbus_en;
    logic        sbus_we;
    logic [1:0]  sbus_size;
    logic [31:0] sbus_addr;
    logic [31:0] sbus_data_w;
    logic [31:0] sbus_data_r;
    logic        sbus_stall;

    sram_to_sbus #(.STALL_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .sram_en(sram_en), .sram_wr(sram_wr), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_stall(sram_stall), .sram_done(sram_done), .sram_err(sram_err),
        .sbus_en(sbus_en), .sbus_we(sbus_we), .sbus_size(sbus_size),
        .sbus_addr(sbus_addr), .sbus_data_w(sbus_data_w),
        .sbus_data_r(sbus_data_r), .sbus_stall(sbus_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    bus_t  bq[$];
    resp_t rq[$];
    int    total = 0;
    int    bad = 0;
    int    stall_left = 0;
    bit    stall_forever = 0;
    bit    en_prev = 0;
    bus_t  cur;

    // Slave model: stalls for a programmed number of cycles per transaction.
    always @(posedge clk) begin
        #1;
        if (sbus_en && (stall_forever || stall_left > 0)) begin
            sbus_stall = 1'b1;
            if (stall_left > 0) stall_left--;
        end else begin
            sbus_stall = 1'b0;
        end
    end

    // Monitor: bus transactions and core responses against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            if (sram_done) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done err=%0b rdata=%h", sram_err, sram_rdata);
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    if (sram_err !== r.err || sram_rdata !== r.rdata) begin
                        bad++;
                        $display("FAIL response got err=%0b rdata=%h want err=%0b rdata=%h",
                                 sram_err, sram_rdata, r.err, r.rdata);
                    end
                end
            end
            if (sbus_en) begin
                total++;
                if (!en_prev) begin
                    if (bq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_bus_en addr=%h", sbus_addr);
                    end else begin
                        cur = bq.pop_front();
                    end
                end
                if (sbus_we !== cur.we || sbus_size !== cur.size ||
                    sbus_addr !== cur.addr || sbus_data_w !== cur.data || sram_stall !== 1'b1) begin
                    bad++;
                    $display("FAIL bus got we=%0b size=%0d addr=%h data=%h stall=%0b want we=%0b size=%0d addr=%h data=%h stall=1",
                             sbus_we, sbus_size, sbus_addr, sbus_data_w, sram_stall,
                             cur.we, cur.size, cur.addr, cur.data);
                end
            end
            en_prev = sbus_en;
        end else begin
            en_prev = 1'b0;
        end
    end

    task automatic issue(input string name, input logic wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] slave_data, input int nstall,
                         input bit bus_ok, input logic [1:0] e_size, input logic [31:0] e_addr,
                         input logic [31:0] e_data, input logic e_err, input logic [31:0] e_rdata,
                         input int e_lat);
        int  lat;
        bit  stalled_ok;
        @(negedge clk);
        if (bus_ok) bq.push_back('{we: wr, size: e_size, addr: e_addr, data: e_data});
        rq.push_back('{err: e_err, rdata: e_rdata});
        stall_left  = nstall;
        sbus_data_r = slave_data;
        sram_en = 1'b1; sram_wr = wr; sram_be = be; sram_addr = addr; sram_wdata = wdata;
        @(posedge clk);
        #1 sram_en = 1'b0;
        lat = 0;
        stalled_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sram_stall !== 1'b1 && !(sram_done && wr && !e_err)) stalled_ok = 1'b0;
            if (sram_done) begin
                lat = k;
                break;
            end
        end
        total++;
        if (lat != e_lat || !stalled_ok) begin
            bad++;
            $display("FAIL %s latency got %0d stall_held=%0b want %0d stall_held=1",
                     name, lat, stalled_ok, e_lat);
        end
    endtask

    initial begin
        rst = 1'b0;
        sram_en = 1'b0; sram_wr = 1'b0; sram_be = 4'h0; sram_addr = '0; sram_wdata = '0;
        sbus_data_r = '0; sbus_stall = 1'b0;
        #12;
        total++;
        if (sbus_en !== 1'b0 || sbus_we !== 1'b0 || sbus_size !== 2'd0 || sbus_addr !== 32'h0 ||
            sbus_data_w !== 32'h0 || sram_stall !== 1'b0 || sram_done !== 1'b0 ||
            sram_err !== 1'b0 || sram_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state en=%0b stall=%0b done=%0b err=%0b rdata=%h addr=%h",
                     sbus_en, sram_stall, sram_done, sram_err, sram_rdata, sbus_addr);
        end
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);

        issue("word_wr", 1'b1, 4'b1111, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0,
              1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1);
        issue("byte_wr", 1'b1, 4'b0100, 32'h0000_0080, 32'h00AB_0000, 32'h0, 0,
              1'b1, 2'd0, 32'h0000_0082, 32'h0000_00AB, 1'b0, 32'h0, 1);
        issue("half_rd", 1'b0, 4'b1100, 32'h0000_0040, 32'h5555_0000, 32'h0000_1234, 0,
              1'b1, 2'd1, 32'h0000_0042, 32'h0000_5555, 1'b0, 32'h1234_0000, 2);
        issue("byte_rd_stall3", 1'b0, 4'b0010, 32'h2000_0013, 32'h0000_7700, 32'hFFFF_FF5A, 3,
              1'b1, 2'd0, 32'h2000_0011, 32'h0000_0077, 1'b0, 32'h0000_5A00, 5);
        issue("illegal_0110", 1'b1, 4'b0110, 32'h0000_0100, 32'h1234_5678, 32'h0, 0,
              1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1);
        issue("word_rd_stall1", 1'b0, 4'b1111, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1,
              1'b1, 2'd2, 32'h0000_0300, 32'h0, 1'b0, 32'hCAFE_F00D, 3);
        issue("half_wr_stall2", 1'b1, 4'b0011, 32'h0000_7FFC, 32'h1111_BEEF, 32'h0, 2,
              1'b1, 2'd1, 32'h0000_7FFC, 32'h1111_BEEF, 1'b0, 32'h0, 3);
        issue("byte3_rd", 1'b0, 4'b1000, 32'h0000_0004, 32'h0, 32'h0000_00C3, 0,
              1'b1, 2'd0, 32'h0000_0007, 32'h0, 1'b0, 32'hC300_0000, 2);
        issue("illegal_0000", 1'b0, 4'b0000, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 0,
              1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1);
        issue("illegal_1010", 1'b0, 4'b1010, 32'h0000_0204, 32'h0, 32'hFFFF_FFFF, 0,
              1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1);

        // Idle with sram_en low: any bus activity would hit an empty queue.
        repeat (5) @(negedge clk);

`ifdef SRAM_TO_SBUS_TIMEOUT_EN
        stall_forever = 1'b1;
        issue("timeout_rd", 1'b0, 4'b1111, 32'h0000_0500, 32'h0, 32'h0, 0,
              1'b1, 2'd2, 32'h0000_0500, 32'h0, 1'b1, 32'h0, 5);
        stall_forever = 1'b0;
        @(negedge clk);
        total++;
        if (sbus_en !== 1'b0) begin
            bad++;
            $display("FAIL timeout_release en=%0b want 0", sbus_en);
        end
`endif

        // Reset in the middle of a stalled transaction.
        @(negedge clk);
        stall_forever = 1'b1;
        bq.push_back('{we: 1'b1, size: 2'd2, addr: 32'h0000_0600, data: 32'hA5A5_A5A5});
        sram_en = 1'b1; sram_wr = 1'b1; sram_be = 4'b1111;
        sram_addr = 32'h0000_0600; sram_wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 sram_en = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (sbus_en !== 1'b0 || sram_stall !== 1'b0 || sram_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset en=%0b stall=%0b done=%0b want 0 0 0",
                     sbus_en, sram_stall, sram_done);
        end
        stall_forever = 1'b0;
        @(negedge clk) rst = 1'b1;

        issue("post_reset_wr", 1'b1, 4'b0001, 32'h0000_0700, 32'h0000_003C, 32'h0, 0,
              1'b1, 2'd0, 32'h0000_0700, 32'h0000_003C, 1'b0, 32'h0, 1);

        repeat (3) @(negedge clk);
        total++;
        if (bq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect bus=%0d resp=%0d want 0 0", bq.size(), rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
